// File: rtl/axil_regbank_if.sv
// AXI4-Lite slave-side bus bundle for axil_regbank.
// Signal names match the flat S_AXI_* ports of the original block.
//   master : interconnect side (drives addresses, data, valids, BREADY/RREADY)
//   slave  : register bank side (drives readies, responses, read data)
interface axil_regbank_if #(
  parameter int unsigned AW = 8
);
  logic [AW-1:0] S_AXI_AWADDR;
  logic [2:0]    S_AXI_AWPROT;
  logic          S_AXI_AWVALID;
  logic          S_AXI_AWREADY;
  logic [31:0]   S_AXI_WDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic          S_AXI_WVALID;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY;
  logic [AW-1:0] S_AXI_ARADDR;
  logic [2:0]    S_AXI_ARPROT;
  logic          S_AXI_ARVALID;
  logic          S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, input S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, input S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID, input S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, input S_AXI_RREADY
  );
endinterface

// File: rtl/axil_regbank.sv
// AXI4-Lite register bank: NUM_REGS 32-bit registers, each either a
// read/write control register (driven on ctrl_regs) or a read-only status
// register (RO_MASK bit set, read from status_in).
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   s_axi       : AXI4-Lite slave (axil_regbank_if.slave)
//   ctrl_regs   : control register contents, register i at [32i+31:32i]
//   status_in   : status inputs for read-only registers
//   wr_pulse    : one-cycle strobe per register, high while its update is new
// Optional build macro AXIL_REGBANK_W1C_EN: read-only registers become sticky
// status bits, cleared by writing 1s (set wins over a same-cycle clear).
module axil_regbank #(
  parameter int unsigned         AW        = 8,
  parameter int unsigned         NUM_REGS  = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
  parameter logic [31:0]         RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  axil_regbank_if.slave           s_axi,
  output logic [NUM_REGS*32-1:0]  ctrl_regs,
  input  logic [NUM_REGS*32-1:0]  status_in,
  output logic [NUM_REGS-1:0]     wr_pulse
);
  localparam int unsigned IW = AW - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic                ready_q, ready_d;
  logic                aw_held_q, aw_held_d;
  logic [IW-1:0]       aw_idx_q, aw_idx_d;
  logic                w_held_q, w_held_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                rvalid_q, rvalid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [31:0]         regs_q [NUM_REGS];
  logic [31:0]         regs_d [NUM_REGS];

  logic          awready, wready, arready, exec;
  logic [31:0]   wmask;
  logic [IW-1:0] ar_idx;
  logic          unused_addr_bits;

  // Readies stay low through reset and rise the cycle after it deasserts.
  assign awready = ready_q && !aw_held_q && !bvalid_q;
  assign wready  = ready_q && !w_held_q && !bvalid_q;
  assign arready = ready_q && !rvalid_q;
  assign exec    = aw_held_q && w_held_q && !bvalid_q;
  assign ar_idx  = s_axi.S_AXI_ARADDR[AW-1:2];

  assign unused_addr_bits = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                              s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

  always_comb begin
    ready_d    = 1'b1;
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    wmask      = '0;
    for (int unsigned b = 0; b < 4; b++) wmask[8*b +: 8] = {8{wstrb_q[b]}};

    if (awready && s_axi.S_AXI_AWVALID) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_axi.S_AXI_AWADDR[AW-1:2];
    end
    if (wready && s_axi.S_AXI_WVALID) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi.S_AXI_WDATA;
      wstrb_d  = s_axi.S_AXI_WSTRB;
    end
    if (bvalid_q && s_axi.S_AXI_BREADY) bvalid_d = 1'b0;

    if (exec) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_DECERR;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (32'(aw_idx_q) == i) begin
          if (!RO_MASK[i]) begin
            bresp_d       = RESP_OKAY;
            regs_d[i]     = (regs_q[i] & ~wmask) | (wdata_q & wmask);
            wr_pulse_d[i] = 1'b1;
          end else begin
`ifdef AXIL_REGBANK_W1C_EN
            bresp_d       = RESP_OKAY;
            regs_d[i]     = regs_q[i] & ~(wdata_q & wmask);
            wr_pulse_d[i] = 1'b1;
`else
            bresp_d       = RESP_SLVERR;
`endif
          end
        end
      end
    end

`ifdef AXIL_REGBANK_W1C_EN
    // Applied after the clear so a same-cycle set wins.
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (RO_MASK[i]) regs_d[i] = regs_d[i] | status_in[32*i +: 32];
    end
`endif

    if (rvalid_q && s_axi.S_AXI_RREADY) rvalid_d = 1'b0;
    if (arready && s_axi.S_AXI_ARVALID) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_DECERR;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (32'(ar_idx) == i) begin
          rresp_d = RESP_OKAY;
`ifdef AXIL_REGBANK_W1C_EN
          rdata_d = regs_q[i];
`else
          rdata_d = RO_MASK[i] ? status_in[32*i +: 32] : regs_q[i];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q    <= 1'b0;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      wr_pulse_q <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RO_MASK[i] ? '0 : RESET_VAL;
    end else begin
      ready_q    <= ready_d;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  always_comb begin
    ctrl_regs = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      ctrl_regs[32*i +: 32] = RO_MASK[i] ? 32'h0 : regs_q[i];
    end
  end

  assign wr_pulse             = wr_pulse_q;
  assign s_axi.S_AXI_AWREADY  = awready;
  assign s_axi.S_AXI_WREADY   = wready;
  assign s_axi.S_AXI_BVALID   = bvalid_q;
  assign s_axi.S_AXI_BRESP    = bresp_q;
  assign s_axi.S_AXI_ARREADY  = arready;
  assign s_axi.S_AXI_RVALID   = rvalid_q;
  assign s_axi.S_AXI_RDATA    = rdata_q;
  assign s_axi.S_AXI_RRESP    = rresp_q;
endmodule

// File: tb/tb_axil_regbank.sv
// Directed bench for axil_regbank (NUM_REGS=8, register 2 read-only,
// control reset value 0xA5). Covers both builds of AXIL_REGBANK_W1C_EN.
module tb_axil_regbank;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [255:0]  ctrl_regs;
  logic [255:0]  status_in = '0;
  logic [7:0]    wr_pulse;
  int            checks = 0;
  int            failures = 0;
  logic [1:0]    resp;
  logic [7:0]    pulse;
  logic [31:0]   rdata;
  logic [1:0]    rresp;

  axil_regbank_if #(.AW(8)) bus ();

  axil_regbank #(
    .AW(8), .NUM_REGS(8), .RO_MASK(8'h04), .RESET_VAL(32'h0000_00A5)
  ) dut (
    .clk(clk), .reset(reset), .s_axi(bus),
    .ctrl_regs(ctrl_regs), .status_in(status_in), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge where BVALID is first seen.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_delay, input int w_delay,
                           output logic [1:0] r, output logic [7:0] p);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    int cyc = 0;
    bus.S_AXI_AWADDR = addr;
    bus.S_AXI_WDATA  = data;
    bus.S_AXI_WSTRB  = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (cyc >= aw_delay && !aw_done) bus.S_AXI_AWVALID = 1'b1;
      if (cyc >= w_delay && !w_done) bus.S_AXI_WVALID = 1'b1;
      aw_fire = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_fire  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      step();
      cyc++;
      if (aw_fire) begin bus.S_AXI_AWVALID = 1'b0; aw_done = 1; end
      if (w_fire)  begin bus.S_AXI_WVALID = 1'b0; w_done = 1; end
    end
    check("wr_handshakes", {30'd0, aw_done, w_done}, 32'd3);
    cyc = 0;
    while (!bus.S_AXI_BVALID && cyc < 20) begin step(); cyc++; end
    check("b_latency", cyc, 1);
    r = bus.S_AXI_BRESP;
    p = wr_pulse;
  endtask

  // Called at a negedge; returns at the negedge after the AR handshake.
  task automatic axi_read(input logic [7:0] addr, output logic [31:0] d, output logic [1:0] r);
    int cyc = 0;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    while (!bus.S_AXI_ARREADY && cyc < 20) begin step(); cyc++; end
    step();
    bus.S_AXI_ARVALID = 1'b0;
    check("r_latency", bus.S_AXI_RVALID, 1);
    d = bus.S_AXI_RDATA;
    r = bus.S_AXI_RRESP;
  endtask

  initial begin
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b1;

    // Reset state
    repeat (3) step();
    check("rst_awready", bus.S_AXI_AWREADY, 0);
    check("rst_wready", bus.S_AXI_WREADY, 0);
    check("rst_arready", bus.S_AXI_ARREADY, 0);
    check("rst_bvalid", bus.S_AXI_BVALID, 0);
    check("rst_rvalid", bus.S_AXI_RVALID, 0);
    check("rst_rdata", bus.S_AXI_RDATA, 0);
    check("rst_pulse", wr_pulse, 0);
    check("rst_reg0", ctrl_regs[31:0], 32'hA5);
    check("rst_reg2_ro", ctrl_regs[95:64], 32'h0);
    check("rst_reg7", ctrl_regs[255:224], 32'hA5);
    reset = 1'b0;
    step();
    check("post_rst_awready", bus.S_AXI_AWREADY, 1);
    check("post_rst_arready", bus.S_AXI_ARREADY, 1);

    // Full write, AW three cycles ahead of W
    axi_write(8'h00, 32'h0000_1234, 4'hF, 0, 3, resp, pulse);
    check("w0_bresp", resp, 0);
    check("w0_pulse", pulse, 8'h01);
    check("w0_reg0", ctrl_regs[31:0], 32'h1234);
    step();
    check("w0_pulse_end", wr_pulse, 0);
    axi_read(8'h00, rdata, rresp);
    check("r0_data", rdata, 32'h1234);
    check("r0_resp", rresp, 0);

    // Byte lanes; second write has W ahead of AW
    axi_write(8'h04, 32'hAABB_CCDD, 4'hF, 0, 0, resp, pulse);
    check("w1_pulse", pulse, 8'h02);
    axi_write(8'h04, 32'h1122_3344, 4'h5, 2, 0, resp, pulse);
    check("w1s_bresp", resp, 0);
    axi_read(8'h04, rdata, rresp);
    check("r1_strb", rdata, 32'hAA22_CC44);
    axi_read(8'h07, rdata, rresp);
    check("r1_unaligned", rdata, 32'hAA22_CC44);

    // Out of range
    axi_write(8'h20, 32'hDEAD_BEEF, 4'hF, 0, 0, resp, pulse);
    check("wdec_bresp", resp, 3);
    check("wdec_pulse", pulse, 0);
    axi_read(8'h20, rdata, rresp);
    check("rdec_data", rdata, 0);
    check("rdec_resp", rresp, 3);

    // WSTRB = 0 still pulses, contents unchanged
    axi_write(8'h00, 32'hFFFF_FFFF, 4'h0, 0, 0, resp, pulse);
    check("wz_bresp", resp, 0);
    check("wz_pulse", pulse, 8'h01);
    check("wz_reg0", ctrl_regs[31:0], 32'h1234);

`ifdef AXIL_REGBANK_W1C_EN
    status_in[95:64] = 32'hCAFE_F00D;
    step();
    status_in[95:64] = 32'h0;
    axi_read(8'h08, rdata, rresp);
    check("w1c_sticky", rdata, 32'hCAFE_F00D);
    axi_write(8'h08, 32'hFFFF_0000, 4'hF, 0, 0, resp, pulse);
    check("w1c_bresp", resp, 0);
    check("w1c_pulse", pulse, 8'h04);
    axi_read(8'h08, rdata, rresp);
    check("w1c_partial", rdata, 32'h0000_F00D);
    axi_write(8'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, resp, pulse);
    axi_read(8'h08, rdata, rresp);
    check("w1c_all_clear", rdata, 32'h0);
    status_in[67] = 1'b1;
    step();
    status_in[67] = 1'b0;
    axi_read(8'h08, rdata, rresp);
    check("w1c_bit3_set", rdata, 32'h8);
    axi_write(8'h08, 32'h8, 4'hF, 0, 0, resp, pulse);
    check("w1c_bit3_bresp", resp, 0);
    axi_read(8'h08, rdata, rresp);
    check("w1c_bit3_clear", rdata, 32'h0);
    // Status held high through the commit edge, dropped right after it
    status_in[67] = 1'b1;
    axi_write(8'h08, 32'h8, 4'hF, 0, 0, resp, pulse);
    status_in[67] = 1'b0;
    axi_read(8'h08, rdata, rresp);
    check("w1c_set_wins", rdata, 32'h8);
    check("w1c_ctrl_slot", ctrl_regs[95:64], 32'h0);
`else
    status_in[95:64] = 32'hCAFE_F00D;
    axi_read(8'h08, rdata, rresp);
    check("ro_rdata", rdata, 32'hCAFE_F00D);
    check("ro_rresp", rresp, 0);
    axi_write(8'h08, 32'h1234_5678, 4'hF, 0, 0, resp, pulse);
    check("ro_bresp", resp, 2);
    check("ro_pulse", pulse, 0);
    check("ro_ctrl_slot", ctrl_regs[95:64], 32'h0);
    status_in[95:64] = 32'h0BAD_CAFE;
    axi_read(8'h08, rdata, rresp);
    check("ro_live", rdata, 32'h0BAD_CAFE);
`endif

    // B backpressure: stalled DECERR response, second write waits
    bus.S_AXI_BREADY = 1'b0;
    axi_write(8'h20, 32'h0, 4'hF, 0, 0, resp, pulse);
    check("bp_first", resp, 3);
    bus.S_AXI_AWADDR = 8'h10; bus.S_AXI_WDATA = 32'h66; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_awready", bus.S_AXI_AWREADY, 0);
      check("bp_wready", bus.S_AXI_WREADY, 0);
      check("bp_bvalid", bus.S_AXI_BVALID, 1);
      check("bp_bresp", bus.S_AXI_BRESP, 3);
    end
    check("bp_reg4_held", ctrl_regs[159:128], 32'hA5);
    bus.S_AXI_BREADY = 1'b1;
    step();
    check("bp_bvalid_drop", bus.S_AXI_BVALID, 0);
    axi_write(8'h10, 32'h66, 4'hF, 0, 0, resp, pulse);
    check("bp_second_bresp", resp, 0);
    check("bp_second_pulse", pulse, 8'h10);
    check("bp_reg4", ctrl_regs[159:128], 32'h66);

    // Reset with AW held: the later W alone must not complete a write
    step();
    bus.S_AXI_AWADDR = 8'h00;
    bus.S_AXI_AWVALID = 1'b1;
    step();
    bus.S_AXI_AWVALID = 1'b0;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    check("mid_rst_reg0", ctrl_regs[31:0], 32'hA5);
    step();
    check("mid_rst_wready", bus.S_AXI_WREADY, 1);
    bus.S_AXI_WDATA = 32'h9999; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    step();
    bus.S_AXI_WVALID = 1'b0;
    repeat (3) step();
    check("mid_rst_bvalid", bus.S_AXI_BVALID, 0);
    check("mid_rst_pulse", wr_pulse, 0);
    check("mid_rst_reg0_kept", ctrl_regs[31:0], 32'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
